uart_tx: RTL

//   UART transmitter; the transmit-side companion of the uart_rx receiver.
//   - Accepts bytes over a valid/ready handshake into a small FIFO.
//   - Serialises each byte as 8N1, LSB first, on tx at CLKS_PER_BIT clk cycles per bit.
//   - Drives the host-bound serial line on the same baud settings as uart_rx.

---
 rtl/uart_tx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, 8N1 LSB first; define UART_TX_PARITY_EN
// to insert a parity bit (sense set by PARITY_ODD) between bit 7 and the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_dv,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam bit unused_parity_odd = PARITY_ODD;
`endif
  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d, done_q, done_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push, pop, empty, last;
  assign tx_ready = cnt_q != (AW+1)'(FIFO_DEPTH);
  assign push     = tx_dv && tx_ready;
  assign empty    = cnt_q == '0;
  assign last     = clk_cnt_q == LAST;
  assign tx       = tx_q;
  assign tx_busy  = state_q != S_IDLE;
  assign tx_done  = done_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= tx_byte;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      wr_q      <= wr_q + AW'(push);
      rd_q      <= rd_q + AW'(pop);
      cnt_q     <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  // The stop bit pops the next byte itself so queued frames run with no idle gap.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = last ? '0 : clk_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        tx_d      = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_q];
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START:
        if (last) begin
          tx_d      = data_q[0];
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      S_DATA:
        if (last) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = ^data_q ^ PARITY_ODD;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = data_q[bit_idx_d];
          end
        end
`ifdef UART_TX_PARITY_EN
      S_PARITY:
        if (last) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
`endif
      S_STOP:
        if (last) begin
          done_d = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
